// File: rtl/ghost_dir_gen.sv
// Round-robin random direction generator, one channel per ghost; GHOST_NO_REVERSE_EN avoids reversals except at dead ends.
// Latency 4..7 cycles from req to done; requests never stall, repeats merge into a per-channel pending bit.
module ghost_dir_gen #(
    parameter int          NUM_GHOSTS = 4,
    parameter int          LFSR_W     = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_GHOSTS-1:0]     req,
    input  logic [4*NUM_GHOSTS-1:0]   allowed,
    output logic [8*NUM_GHOSTS-1:0]   dir,
    output logic [NUM_GHOSTS-1:0]     done,
    output logic [NUM_GHOSTS-1:0]     stuck,
    output logic                      busy
);

    localparam int                CH_W     = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_W'(1) : LFSR_W'(SEED);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_SCAN, S_COMMIT} state_t;

    state_t                  state_q, state_d;
    logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
    logic [NUM_GHOSTS-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]         rr_q, rr_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [3:0]              mask_q, mask_d;
    logic [1:0]              cand_q, cand_d;
    logic [1:0]              scan_cnt_q, scan_cnt_d;
    logic                    stuck_q, stuck_d;
    logic [2*NUM_GHOSTS-1:0] idx_q, idx_d;

    logic                    found;
    logic [CH_W-1:0]         pick_ch;
    logic [NUM_GHOSTS-1:0]   clr;
    int                      scan_idx;
`ifdef GHOST_NO_REVERSE_EN
    logic [1:0]              cur_idx;
    logic [3:0]              rmask;
`endif

    function automatic logic [7:0] keycode(input logic [1:0] i);
        case (i)
            2'd0:    keycode = 8'h04;
            2'd1:    keycode = 8'h07;
            2'd2:    keycode = 8'h16;
            default: keycode = 8'h1A;
        endcase
    endfunction

    always_comb begin
        found    = 1'b0;
        pick_ch  = '0;
        scan_idx = 0;
        // Descending offsets so the nearest pending channel after rr_q wins.
        for (int k = NUM_GHOSTS - 1; k >= 0; k--) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_GHOSTS) scan_idx = scan_idx - NUM_GHOSTS;
            if (pending_q[CH_W'(scan_idx)]) begin
                found   = 1'b1;
                pick_ch = CH_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        rr_d       = rr_q;
        ch_d       = ch_q;
        mask_d     = mask_q;
        cand_d     = cand_q;
        scan_cnt_d = scan_cnt_q;
        stuck_d    = stuck_q;
        idx_d      = idx_q;
        clr        = '0;
`ifdef GHOST_NO_REVERSE_EN
        cur_idx    = idx_q[{ch_q, 1'b0} +: 2];
        rmask      = 4'b0001 << (cur_idx ^ 2'b01);
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ch_d    = pick_ch;
                    mask_d  = allowed[{pick_ch, 2'b00} +: 4];
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cand_d     = lfsr_q[1:0];
                scan_cnt_d = 2'd0;
                stuck_d    = 1'b0;
`ifdef GHOST_NO_REVERSE_EN
                if ((mask_q & ~rmask) != 4'b0000) mask_d = mask_q & ~rmask;
`endif
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                if (mask_q == 4'b0000) begin
                    stuck_d = 1'b1;
                    state_d = S_COMMIT;
                end else if (mask_q[cand_q]) begin
                    idx_d[{ch_q, 1'b0} +: 2] = cand_q;
                    state_d = S_COMMIT;
                end else if (scan_cnt_q == 2'd3) begin
                    // A nonzero mask always hits within four candidates; kept as a safe exit.
                    stuck_d = 1'b1;
                    state_d = S_COMMIT;
                end else begin
                    cand_d     = cand_q + 2'd1;
                    scan_cnt_d = scan_cnt_q + 2'd1;
                end
            end
            default: begin
                clr[ch_q] = 1'b1;
                rr_d      = (ch_q == CH_W'(NUM_GHOSTS - 1)) ? '0 : ch_q + 1'b1;
                state_d   = S_IDLE;
            end
        endcase
        // A request landing in the commit cycle re-arms the channel.
        pending_d = (pending_q & ~clr) | req;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_EFF;
            pending_q  <= '0;
            rr_q       <= '0;
            ch_q       <= '0;
            mask_q     <= '0;
            cand_q     <= '0;
            scan_cnt_q <= '0;
            stuck_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            ch_q       <= ch_d;
            mask_q     <= mask_d;
            cand_q     <= cand_d;
            scan_cnt_q <= scan_cnt_d;
            stuck_q    <= stuck_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        done  = '0;
        stuck = '0;
        if (state_q == S_COMMIT) begin
            done[ch_q]  = 1'b1;
            stuck[ch_q] = stuck_q;
        end
    end

    assign busy = (state_q != S_IDLE);

    for (genvar c = 0; c < NUM_GHOSTS; c++) begin : g_dir
        assign dir[8*c +: 8] = keycode(idx_q[2*c +: 2]);
    end

endmodule

// File: tb/tb_ghost_dir_gen.sv
// Randomized self-checking bench for ghost_dir_gen against a transaction-level draw model.
module tb_ghost_dir_gen;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [15:0] allowed = 16'h0;
    logic [31:0] dir;
    logic [3:0]  done;
    logic [3:0]  stuck;
    logic        busy;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;
    int          m_idx[4];

    ghost_dir_gen #(.NUM_GHOSTS(4), .LFSR_W(16), .SEED(16'hACE1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .allowed(allowed),
        .dir(dir), .done(done), .stuck(stuck), .busy(busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running reference LFSR: one Galois step per clock out of reset.
    always @(posedge Clk or negedge Reset_n)
        if (!Reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= lfsr_next(m_lfsr);

    function automatic logic [7:0] kc(input int i);
        case (i)
            0:       return 8'h04;
            1:       return 8'h07;
            2:       return 8'h16;
            default: return 8'h1A;
        endcase
    endfunction

    function automatic logic [31:0] exp_dirs();
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[8*c +: 8] = kc(m_idx[c]);
        return v;
    endfunction

    // Draw rule: first legal direction from the LFSR's low bits, wrapping upward.
    function automatic void predict(input logic [15:0] ls, input logic [3:0] m, input int cur,
                                    output int nd, output int steps, output bit stk);
        logic [3:0] eff;
        int cand;
        eff = m;
`ifdef GHOST_NO_REVERSE_EN
        begin
            logic [3:0] r;
            r = 4'b0001 << (cur ^ 1);
            if ((m & ~r) != 4'b0000) eff = m & ~r;
        end
`endif
        stk   = (eff == 4'b0000);
        nd    = cur;
        steps = 0;
        cand  = int'(ls[1:0]);
        if (!stk)
            for (int s = 3; s >= 0; s--)
                if (eff[(cand + s) % 4]) begin
                    nd    = (cand + s) % 4;
                    steps = s;
                end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        req     = 4'h0;
        for (int c = 0; c < 4; c++) m_idx[c] = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // One isolated draw; req held for 'hold' cycles. 'now' starts in the current cycle.
    task automatic draw(input int c, input logic [3:0] m, input int hold, input bit now);
        int          cyc;
        bit          got;
        logic [15:0] ls;
        int          nd, steps;
        bit          stk;
        if (!now) @(negedge Clk);
        allowed[4*c +: 4] = m;
        req[c] = 1'b1;
        cyc = 0;
        got = 1'b0;
        ls  = '0;
        while (!got && cyc < 20) begin
            @(negedge Clk);
            cyc++;
            if (cyc == hold) req[c] = 1'b0;
            if (cyc == 2) ls = m_lfsr;
            if (done != 4'h0) got = 1'b1;
        end
        req[c] = 1'b0;
        check("draw_timeout", 32'(got), 32'd1);
        predict(ls, m, m_idx[c], nd, steps, stk);
        if (!stk) m_idx[c] = nd;
        check("draw_latency", 32'(cyc), 32'(4 + steps));
        check("draw_done", 32'(done), 32'(4'b0001 << c));
        check("draw_stuck", 32'(stuck), stk ? 32'(4'b0001 << c) : 32'd0);
        check("draw_dir", dir, exp_dirs());
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (done != 4'h0) n++;
        end
    endtask

    initial begin
        int  n;
        int  order[$];
        bit  saw04, saw07;
        for (int c = 0; c < 4; c++) m_idx[c] = 0;

        // Reset values and requests ignored while in reset.
        #1;
        check("rst_dir", dir, 32'h04040404);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge Clk);
        req = 4'hF;
        @(negedge Clk);
        req = 4'h0;
        Reset_n = 1'b1;
        count_done(12, n);
        check("rst_no_done", 32'(n), 32'd0);

        // Single legal direction.
        draw(0, 4'b1000, 1, 1'b0);
        check("single_up", 32'(dir[7:0]), 32'h1A);

        // Round-robin arbitration.
        do_reset();
        @(negedge Clk);
        allowed = 16'h2222;
        req = 4'hF;
        @(negedge Clk);
        req = 4'h0;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            if (done != 4'h0) begin
                check("arb_order", 32'(done), 32'(4'b0001 << order.size()));
                check("arb_stuck", 32'(stuck), 32'd0);
                order.push_back(i);
            end
            if (order.size() < 4) @(negedge Clk);
        end
        check("arb_count", 32'(order.size()), 32'd4);
        check("arb_dirs", dir, 32'h07070707);
        @(negedge Clk);
        check("arb_idle", 32'(busy), 32'd0);
        for (int c = 0; c < 4; c++) m_idx[c] = 1;

        // Blocked channel.
        do_reset();
        draw(1, 4'b0000, 1, 1'b0);
        check("blocked_stuck", 32'(stuck[1]), 32'd1);
        check("blocked_dir", 32'(dir[15:8]), 32'h04);

        // Reversal behaviour from left with left/right legal.
        do_reset();
        saw04 = 1'b0;
        saw07 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            draw(0, 4'b0011, 1, 1'b0);
            if (dir[7:0] == 8'h04) saw04 = 1'b1;
            if (dir[7:0] == 8'h07) saw07 = 1'b1;
        end
`ifdef GHOST_NO_REVERSE_EN
        check("norev_left", 32'(saw04), 32'd1);
        check("norev_never_right", 32'(saw07), 32'd0);
`else
        check("rev_left_seen", 32'(saw04), 32'd1);
        check("rev_right_seen", 32'(saw07), 32'd1);
`endif
        draw(0, 4'b0010, 1, 1'b0);
        check("deadend_right", 32'(dir[7:0]), 32'h07);

        // Held request merges into a single draw.
        draw(2, 4'b1111, 3, 1'b0);
        count_done(10, n);
        check("merge_single", 32'(n), 32'd0);

        // Request in the commit cycle re-arms the channel.
        draw(3, 4'($urandom_range(1, 15)), 1, 1'b0);
        draw(3, 4'($urandom_range(0, 15)), 1, 1'b1);

        // Random isolated draws.
        for (int i = 0; i < 40; i++)
            draw($urandom_range(0, 3), 4'($urandom_range(0, 15)), $urandom_range(1, 3), 1'b0);

        // Reset mid-scan.
        do_reset();
        @(negedge Clk);
        allowed[3:0] = 4'b1111;
        req[0] = 1'b1;
        @(negedge Clk);
        req[0] = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("midrst_busy_pre", 32'(busy), 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        check("midrst_dir", dir, 32'h04040404);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_stuck", 32'(stuck), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        count_done(12, n);
        check("midrst_no_done", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
